// File: rtl/fp_pkg.sv
// Shared types and constants for the fp_addsub_seq single-precision add/subtract sequencer.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0]      QNAN      = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_INF   = 8'hFF;
  localparam logic [EXP_W-1:0] ALIGN_MAX = 8'd25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ADD    = 3'd3,
    ST_NORM   = 3'd4,
    ST_ROUND  = 3'd5,
    ST_DONE   = 3'd6
  } fp_state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack and classification of one IEEE-754 single operand.
module fp_classify import fp_pkg::*; (
  input  logic [31:0]  x,
  output fp_unpacked_t u
);

  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] frac_s;
  logic             exp_zero_s;
  logic             exp_max_s;
  logic             frac_zero_s;

  assign exp_s       = x[30:23];
  assign frac_s      = x[22:0];
  assign exp_zero_s  = (exp_s == {EXP_W{1'b0}});
  assign exp_max_s   = (exp_s == EXP_INF);
  assign frac_zero_s = (frac_s == {MAN_W{1'b0}});

  // Field extraction and class flags; denormals are treated as zero
  always_comb begin
    u.sign    = x[31];
    u.exp     = exp_s;
    u.is_zero = exp_zero_s;
    u.is_inf  = exp_max_s & frac_zero_s;
    u.is_nan  = exp_max_s & ~frac_zero_s;
    if (exp_zero_s) begin
      u.mant = {(MAN_W+1){1'b0}};
    end else begin
      u.mant = {1'b1, frac_s};
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single add/subtract driving an external 24-bit mantissa ALU.
// Define FPADD_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_seq import fp_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             busy,
  output logic [MAN_W:0]   alu_op1,
  output logic [MAN_W:0]   alu_op2,
  output logic             alu_operator,
  input  logic [MAN_W+1:0] alu_out
);

`ifdef FPADD_ROUND_EN
  localparam fp_state_e FIN_ST = ST_ROUND;
`else
  localparam fp_state_e FIN_ST = ST_DONE;
`endif

  fp_state_e        state_r, state_s;
  logic [31:0]      a_r, a_s, b_r, b_s;
  logic             sign_a_r, sign_a_s, sign_b_r, sign_b_s;
  logic [EXP_W-1:0] exp_r, exp_s, d_r, d_s;
  logic [MAN_W+1:0] man_r, man_s;
  logic [MAN_W:0]   mant_b_r, mant_b_s;
  logic [2:0]       grs_r, grs_s;
  logic             borrow_r, borrow_s, special_r, special_s;
  logic [MAN_W:0]   alu_op1_s, alu_op2_s;
  logic             alu_operator_s;

  fp_unpacked_t     ua_s, ub_s, big_s, small_s;
  logic [30:0]      mag_a_s, mag_b_s;
  logic             swap_s, nan_s;
  logic [MAN_W+1:0] cur_s;
  logic [2:0]       cur_grs_s;

  fp_classify u_cls_a (.x(a_r), .u(ua_s));
  fp_classify u_cls_b (.x(b_r), .u(ub_s));

  // Flushed denormals compare as zero so they never win the swap
  assign mag_a_s   = ua_s.is_zero ? 31'd0 : a_r[30:0];
  assign mag_b_s   = ub_s.is_zero ? 31'd0 : b_r[30:0];
  assign swap_s    = (mag_a_s < mag_b_s);
  assign big_s     = swap_s ? ub_s : ua_s;
  assign small_s   = swap_s ? ua_s : ub_s;
  assign nan_s     = ua_s.is_nan | ub_s.is_nan | (ua_s.is_inf & ub_s.is_inf & (ua_s.sign ^ ub_s.sign));
  // Subtracting a nonzero G/R/S tail borrows one from the mantissa
  assign cur_s     = man_r - {{(MAN_W+1){1'b0}}, borrow_r};
  assign cur_grs_s = borrow_r ? (3'b000 - grs_r) : grs_r;

`ifdef FPADD_ROUND_EN
  logic round_up_s;
  assign round_up_s = grs_r[2] & (grs_r[1] | grs_r[0] | man_r[0]);
`endif

  // Next-state and datapath update for every sequencer step
  always_comb begin
    state_s = state_r;  a_s = a_r;  b_s = b_r;
    sign_a_s = sign_a_r;  sign_b_s = sign_b_r;
    exp_s = exp_r;  man_s = man_r;  mant_b_s = mant_b_r;
    grs_s = grs_r;  d_s = d_r;  borrow_s = borrow_r;  special_s = special_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          a_s     = a;
          b_s     = {b[31] ^ sub, b[30:0]};
          state_s = ST_UNPACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UNPACK: begin
        grs_s     = 3'b000;
        borrow_s  = 1'b0;
        special_s = 1'b0;
        if (nan_s) begin
          special_s = 1'b1;
          sign_a_s  = QNAN[31];
          exp_s     = EXP_INF;
          man_s     = {2'b00, QNAN[MAN_W-1:0]};
          state_s   = ST_NORM;
        end else if (ua_s.is_inf | ub_s.is_inf) begin
          special_s = 1'b1;
          sign_a_s  = ua_s.is_inf ? ua_s.sign : ub_s.sign;
          exp_s     = EXP_INF;
          man_s     = {(MAN_W+2){1'b0}};
          state_s   = ST_NORM;
        end else begin
          sign_a_s = big_s.sign;
          sign_b_s = small_s.sign;
          exp_s    = big_s.exp;
          man_s    = {1'b0, big_s.mant};
          mant_b_s = small_s.mant;
          d_s      = big_s.exp - small_s.exp;
          if (d_s == {EXP_W{1'b0}}) begin
            state_s = ST_ADD;
          end else begin
            state_s = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (d_r > ALIGN_MAX) begin
          mant_b_s = {(MAN_W+1){1'b0}};
          grs_s    = {2'b00, |mant_b_r};
          d_s      = {EXP_W{1'b0}};
          state_s  = ST_ADD;
        end else begin
          mant_b_s = {1'b0, mant_b_r[MAN_W:1]};
          grs_s    = {mant_b_r[0], grs_r[2], grs_r[1] | grs_r[0]};
          d_s      = d_r - {{(EXP_W-1){1'b0}}, 1'b1};
          if (d_r == {{(EXP_W-1){1'b0}}, 1'b1}) begin
            state_s = ST_ADD;
          end else begin
            state_s = ST_ALIGN;
          end
        end
      end
      ST_ADD: begin
        man_s    = alu_out;
        borrow_s = (sign_a_r ^ sign_b_r) & (|grs_r);
        state_s  = ST_NORM;
      end
      ST_NORM: begin
        man_s    = cur_s;
        grs_s    = cur_grs_s;
        borrow_s = 1'b0;
        if (special_r) begin
          man_s   = man_r;
          state_s = ST_DONE;
        end else if (cur_s[MAN_W+1]) begin
          if (exp_r == (EXP_INF - 8'd1)) begin
            exp_s = EXP_INF;
            man_s = {(MAN_W+2){1'b0}};
            grs_s = 3'b000;
          end else begin
            exp_s = exp_r + 8'd1;
            man_s = {1'b0, cur_s[MAN_W+1:1]};
            grs_s = {cur_s[0], cur_grs_s[2], cur_grs_s[1] | cur_grs_s[0]};
          end
          state_s = FIN_ST;
        end else if (cur_s == {(MAN_W+2){1'b0}}) begin
          // Exact cancellation is +0 unless both inputs were negative
          sign_a_s = sign_a_r & sign_b_r;
          exp_s    = {EXP_W{1'b0}};
          grs_s    = 3'b000;
          state_s  = FIN_ST;
        end else if (!cur_s[MAN_W]) begin
          if (exp_r <= 8'd1) begin
            exp_s   = {EXP_W{1'b0}};
            man_s   = {(MAN_W+2){1'b0}};
            grs_s   = 3'b000;
            state_s = FIN_ST;
          end else begin
            exp_s   = exp_r - 8'd1;
            man_s   = {1'b0, cur_s[MAN_W-1:0], cur_grs_s[2]};
            grs_s   = {cur_grs_s[1], cur_grs_s[0], 1'b0};
            state_s = ST_NORM;
          end
        end else begin
          state_s = FIN_ST;
        end
      end
`ifdef FPADD_ROUND_EN
      ST_ROUND: begin
        grs_s = 3'b000;
        if (round_up_s) begin
          if (!alu_out[MAN_W+1]) begin
            man_s = alu_out;
          end else if (exp_r == (EXP_INF - 8'd1)) begin
            exp_s = EXP_INF;
            man_s = {(MAN_W+2){1'b0}};
          end else begin
            exp_s = exp_r + 8'd1;
            man_s = {2'b01, {MAN_W{1'b0}}};
          end
        end else begin
          man_s = man_r;
        end
        state_s = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // ALU operands for the cycle being entered; zero outside ADD and ROUND
  always_comb begin
    alu_op1_s      = {(MAN_W+1){1'b0}};
    alu_op2_s      = {(MAN_W+1){1'b0}};
    alu_operator_s = 1'b0;
    case (state_s)
      ST_ADD: begin
        alu_op1_s      = man_s[MAN_W:0];
        alu_op2_s      = mant_b_s;
        alu_operator_s = sign_a_s ^ sign_b_s;
      end
`ifdef FPADD_ROUND_EN
      ST_ROUND: begin
        alu_op1_s      = man_s[MAN_W:0];
        alu_op2_s      = {{MAN_W{1'b0}}, 1'b1};
        alu_operator_s = 1'b0;
      end
`endif
      default: begin
        alu_op1_s      = {(MAN_W+1){1'b0}};
        alu_op2_s      = {(MAN_W+1){1'b0}};
        alu_operator_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      exp_r     <= {EXP_W{1'b0}};
      man_r     <= {(MAN_W+2){1'b0}};
      mant_b_r  <= {(MAN_W+1){1'b0}};
      grs_r     <= 3'b000;
      d_r       <= {EXP_W{1'b0}};
      borrow_r  <= 1'b0;
      special_r <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= 32'd0;
      alu_op1   <= {(MAN_W+1){1'b0}};
      alu_op2   <= {(MAN_W+1){1'b0}};
      alu_operator <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      sign_a_r  <= sign_a_s;
      sign_b_r  <= sign_b_s;
      exp_r     <= exp_s;
      man_r     <= man_s;
      mant_b_r  <= mant_b_s;
      grs_r     <= grs_s;
      d_r       <= d_s;
      borrow_r  <= borrow_s;
      special_r <= special_s;
      in_ready  <= (state_s == ST_IDLE);
      busy      <= (state_s != ST_IDLE);
      out_valid <= (state_s == ST_DONE);
      if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
        result <= {sign_a_s, exp_s, man_s[MAN_W-1:0]};
      end else begin
        result <= result;
      end
      alu_op1      <= alu_op1_s;
      alu_op2      <= alu_op2_s;
      alu_operator <= alu_operator_s;
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq; expectations follow FPADD_ROUND_EN.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, busy, alu_operator;
  logic [31:0] a, b, result;
  logic [23:0] alu_op1, alu_op2;
  logic [24:0] alu_out;
  int          n_vec = 0;
  int          n_err = 0;

`ifdef FPADD_ROUND_EN
  localparam int          RL      = 1;
  localparam logic [31:0] W_RND_A = 32'h3F800001;
  localparam logic [31:0] W_RND_B = 32'h3F800000;
`else
  localparam int          RL      = 0;
  localparam logic [31:0] W_RND_A = 32'h3F800000;
  localparam logic [31:0] W_RND_B = 32'h3F7FFFFF;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] want;
    int          lat;
  } vec_t;

  fp_addsub_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_operator(alu_operator), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // External mantissa ALU
  assign alu_out = alu_operator ? ({1'b0, alu_op1} - {1'b0, alu_op2})
                                : ({1'b0, alu_op1} + {1'b0, alu_op2});

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       output int lat, output bit to);
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; to = 1'b1;
    for (int i = 1; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_err++; $display("FAIL reset_flags got %b want 001", {out_valid, busy, in_ready});
    end
    n_vec++;
    if (result !== 32'd0) begin
      n_err++; $display("FAIL reset_result got %h want 00000000", result);
    end
    n_vec++;
    if ({alu_op1, alu_op2, alu_operator} !== 49'd0) begin
      n_err++; $display("FAIL reset_alu got %h %h %b want zeros", alu_op1, alu_op2, alu_operator);
    end
  endtask

  task automatic run_table(input string tag, input vec_t v[$]);
    int lat; bit to;
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].s, lat, to);
      n_vec++;
      if (to || result !== v[i].want) begin
        n_err++; $display("FAIL %s[%0d] result got %h want %h (timeout %0d)", tag, i, result, v[i].want, to);
      end
      n_vec++;
      if (lat !== v[i].lat) begin
        n_err++; $display("FAIL %s[%0d] latency got %0d want %0d", tag, i, lat, v[i].lat);
      end
      drain();
      n_vec++;
      if ({out_valid, in_ready, alu_op1, alu_op2, alu_operator} !== {2'b01, 49'd0}) begin
        n_err++; $display("FAIL %s[%0d] idle got ov=%b rdy=%b op1=%h op2=%h opr=%b", tag, i,
                          out_valid, in_ready, alu_op1, alu_op2, alu_operator);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[$];
    v.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3 + RL});
    v.push_back('{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 6 + RL});
    v.push_back('{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3 + RL});
    v.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3 + RL});
    v.push_back('{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 5 + RL});
    v.push_back('{32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4 + RL});
    v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3 + RL});
    v.push_back('{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3 + RL});
    run_table("arith", v);
  endtask

  task automatic test_specials();
    vec_t v[$];
    v.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2});
    v.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2});
    v.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2});
    v.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2});
    v.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2});
    run_table("special", v);
  endtask

  task automatic test_round();
    vec_t v[$];
    v.push_back('{32'h3F800000, 32'h33C00000, 1'b0, W_RND_A,      27 + RL});
    v.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 27 + RL});
    v.push_back('{32'h3F800000, 32'h0C800000, 1'b0, 32'h3F800000, 4 + RL});
    v.push_back('{32'h3F800000, 32'h0C800000, 1'b1, W_RND_B,      5 + RL});
    run_table("round", v);
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    issue(32'h3F800000, 32'h3F800000, 1'b0, lat, to);
    a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (to || result !== 32'h40000000 || {out_valid, in_ready} !== 2'b10) begin
        n_err++; $display("FAIL hold[%0d] got result=%h ov=%b rdy=%b want 40000000 1 0", i,
                          result, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    drain();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL hold_release got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL no_queue got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_pulse();
    int lat; bit to;
    out_ready = 1'b1;
    issue(32'h3F800000, 32'h3F400000, 1'b1, lat, to);
    n_vec++;
    if (to || result !== 32'h3E800000) begin
      n_err++; $display("FAIL pulse_result got %h want 3E800000", result);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL pulse_width got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    a = 32'h3F800000; b = 32'h33C00000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_err++; $display("FAIL abort_flags got %b want 001", {out_valid, busy, in_ready});
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL abort_no_result got out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_arith();
    test_specials();
    test_round();
    test_backpressure();
    test_pulse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
